// File: rtl/zprize_divmod_seq.sv
// Sequential radix-2 restoring divider: W0-bit dividend / W1-bit divisor, one quotient bit per cycle.
// A metadata tag rides along with each operation; divide-by-zero yields all-ones quotient.
module zprize_divmod_seq #(
  parameter int W0 = 98,
  parameter int W1 = 49,
  parameter int M  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W0-1:0] dividend,
  input  logic [W1-1:0] divisor,
  input  logic [M-1:0]  m_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W0-1:0] quotient,
  output logic [W1-1:0] remainder,
  output logic          div0,
  output logic [M-1:0]  m_o
);

  localparam int CW = (W0 > 1) ? $clog2(W0) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W0-1:0] quo_q;
  logic [W1:0]   rem_q;
  logic [W1-1:0] dvs_q;
  logic [W1-1:0] dvd_lo_q;
  logic [M-1:0]  tag_q;
  logic          zero_q;

  logic          out_valid_q;
  logic [W0-1:0] quotient_q;
  logic [W1-1:0] remainder_q;
  logic          div0_q;
  logic [M-1:0]  m_o_q;

  logic [W1:0]   shl_s;
  logic [W1:0]   diff_s;
  logic          ge_s;
  logic [W1:0]   rem_d;
  logic [W0-1:0] quo_d;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shl_s  = {rem_q[W1-1:0], quo_q[W0-1]};
    diff_s = shl_s - {1'b0, dvs_q};
    ge_s   = (shl_s >= {1'b0, dvs_q});
    if (ge_s) begin
      rem_d = diff_s;
    end else begin
      rem_d = shl_s;
    end
    quo_d = {quo_q[W0-2:0], ge_s};
  end

  // Control FSM with datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_lo_q    <= '0;
      tag_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      m_o_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            quo_q    <= dividend;
            dvs_q    <= divisor;
            dvd_lo_q <= dividend[W1-1:0];
            tag_q    <= m_i;
            rem_q    <= '0;
            zero_q   <= (divisor == '0);
            cnt_q    <= CW'(W0 - 1);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            // Zero divisor gets a fixed, X-free override rather than the raw iteration result.
            quotient_q  <= zero_q ? '1 : quo_d;
            remainder_q <= zero_q ? dvd_lo_q : rem_d[W1-1:0];
            div0_q      <= zero_q;
            m_o_q       <= tag_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div0      = div0_q;
  assign m_o       = m_o_q;

endmodule
